// File: rtl/npx_pkg.sv
// npx_pkg: shared types and constants for the NeoPixel frame path.
//   rgb_t       - one pixel colour, packed in strand byte order {g, r, b}
//   RGB_*       - common colour constants
//   seq_state_t - frame sequencer states
package npx_pkg;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_OFF   = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t RGB_RED   = 24'h00FF00;
    localparam rgb_t RGB_BLUE  = 24'h0000FF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GO,
        WAIT_BUSY,
        WAIT_DONE
    } seq_state_t;

endpackage

// File: rtl/npx_frame_sequencer_if.sv
// npx_frame_sequencer_if: pixel-load / go bus between the frame sequencer and
// the NeoPixel strand controller.
//   npx_ready                     controller -> sequencer, ready for load/go
//   npx_pixel                     pixel index being written
//   npx_red/npx_green/npx_blue    colour for npx_pixel
//   npx_load                      per-pixel register write enable
//   npx_go                        start-transfer pulse
// master = sequencer side, slave = controller side.
interface npx_frame_sequencer_if #(
    parameter int IDXW = 5
);
    logic            npx_ready;
    logic [IDXW-1:0] npx_pixel;
    logic [7:0]      npx_red;
    logic [7:0]      npx_green;
    logic [7:0]      npx_blue;
    logic            npx_load;
    logic            npx_go;

    modport master (
        input  npx_ready,
        output npx_pixel, npx_red, npx_green, npx_blue, npx_load, npx_go
    );

    modport slave (
        output npx_ready,
        input  npx_pixel, npx_red, npx_green, npx_blue, npx_load, npx_go
    );
endinterface

// File: rtl/npx_pixel_colour.sv
// npx_pixel_colour: combinational Pong scene lookup for one pixel.
//   i_idx       pixel index
//   i_ball_pos  ball index (>= NUM_NPX means no ball)
//   i_*_rgb     ball, left paddle, right paddle and background colours
//   o_rgb       colour of pixel i_idx: ball > left paddle > right paddle > bg
module npx_pixel_colour
    import npx_pkg::*;
#(
    parameter int NUM_NPX  = 17,
    parameter int PADDLE_W = 2,
    parameter int IDXW     = $clog2(NUM_NPX)
) (
    input  logic [IDXW-1:0] i_idx,
    input  logic [IDXW-1:0] i_ball_pos,
    input  rgb_t            i_ball_rgb,
    input  rgb_t            i_lpad_rgb,
    input  rgb_t            i_rpad_rgb,
    input  rgb_t            i_bg_rgb,
    output rgb_t            o_rgb
);
    localparam logic [IDXW-1:0] LPAD_END   = IDXW'(PADDLE_W);
    localparam logic [IDXW-1:0] RPAD_START = IDXW'(NUM_NPX - PADDLE_W);

    // An out-of-range ball position never equals a valid index, so it
    // simply renders no ball.
    always_comb begin
        if (i_idx == i_ball_pos)
            o_rgb = i_ball_rgb;
        else if (i_idx < LPAD_END)
            o_rgb = i_lpad_rgb;
        else if (i_idx >= RPAD_START)
            o_rgb = i_rpad_rgb;
        else
            o_rgb = i_bg_rgb;
    end
endmodule

// File: rtl/npx_frame_sequencer.sv
// npx_frame_sequencer: captures a Pong scene on request, writes every pixel in
// index order into the strand controller, issues go once the controller is
// stably ready and reports completion after the strand transfer.
//   clock, reset          system clock, asynchronous active-high reset
//   frame_req             one-cycle frame request (coalesced while busy)
//   ball_pos, *_rgb       scene inputs, snapshotted when a frame starts
//   npx                   controller bus (master side)
//   busy                  high from request acceptance until frame_done
//   frame_done            one-cycle pulse after the strand transfer ends
module npx_frame_sequencer
    import npx_pkg::*;
#(
    parameter int NUM_NPX  = 17,
    parameter int PADDLE_W = 2,
    parameter int IDXW     = $clog2(NUM_NPX)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_req,
    input  logic [IDXW-1:0]        ball_pos,
    input  logic [23:0]            ball_rgb,
    input  logic [23:0]            lpad_rgb,
    input  logic [23:0]            rpad_rgb,
    input  logic [23:0]            bg_rgb,
    npx_frame_sequencer_if.master  npx,
    output logic                   busy,
    output logic                   frame_done
);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NPX - 1);

    seq_state_t      r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_pending;
    logic            r_ready_q;
    logic            r_frame_done;
    logic [IDXW-1:0] r_ball_pos;
    rgb_t            r_ball_rgb;
    rgb_t            r_lpad_rgb;
    rgb_t            r_rpad_rgb;
    rgb_t            r_bg_rgb;

    logic            w_in_load;
    logic            w_go;
    rgb_t            w_rgb;

    npx_pixel_colour #(
        .NUM_NPX  (NUM_NPX),
        .PADDLE_W (PADDLE_W),
        .IDXW     (IDXW)
    ) u_colour (
        .i_idx      (r_idx),
        .i_ball_pos (r_ball_pos),
        .i_ball_rgb (r_ball_rgb),
        .i_lpad_rgb (r_lpad_rgb),
        .i_rpad_rgb (r_rpad_rgb),
        .i_bg_rgb   (r_bg_rgb),
        .o_rgb      (w_rgb)
    );

    assign w_in_load = (r_state == LOAD);
    // Requiring ready on two consecutive cycles skips the controller's
    // single-cycle done-ready pulse, during which go would be ignored.
    assign w_go      = (r_state == GO) && npx.npx_ready && r_ready_q;

    assign npx.npx_load  = w_in_load && npx.npx_ready;
    assign npx.npx_go    = w_go;
    assign npx.npx_pixel = w_in_load ? r_idx   : '0;
    assign npx.npx_red   = w_in_load ? w_rgb.r : 8'h00;
    assign npx.npx_green = w_in_load ? w_rgb.g : 8'h00;
    assign npx.npx_blue  = w_in_load ? w_rgb.b : 8'h00;
    assign busy          = (r_state != IDLE);
    assign frame_done    = r_frame_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_ready_q    <= 1'b0;
            r_frame_done <= 1'b0;
            r_ball_pos   <= '0;
            r_ball_rgb   <= RGB_OFF;
            r_lpad_rgb   <= RGB_OFF;
            r_rpad_rgb   <= RGB_OFF;
            r_bg_rgb     <= RGB_OFF;
        end else begin
            r_ready_q    <= npx.npx_ready;
            r_frame_done <= 1'b0;

            // Requests while a frame is in flight coalesce into one.
            if (frame_req && r_state != IDLE)
                r_pending <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (frame_req) begin
                        r_ball_pos <= ball_pos;
                        r_ball_rgb <= rgb_t'(ball_rgb);
                        r_lpad_rgb <= rgb_t'(lpad_rgb);
                        r_rpad_rgb <= rgb_t'(rpad_rgb);
                        r_bg_rgb   <= rgb_t'(bg_rgb);
                        r_idx      <= '0;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (npx.npx_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= GO;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end
                GO: begin
                    if (w_go)
                        r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Ready falling means the controller took the transfer.
                    if (!npx.npx_ready)
                        r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (npx.npx_ready) begin
                        r_frame_done <= 1'b1;
                        // A request arriving with done is serviced at once;
                        // the scene is sampled now, not at request time.
                        if (r_pending || frame_req) begin
                            r_pending  <= 1'b0;
                            r_ball_pos <= ball_pos;
                            r_ball_rgb <= rgb_t'(ball_rgb);
                            r_lpad_rgb <= rgb_t'(lpad_rgb);
                            r_rpad_rgb <= rgb_t'(rpad_rgb);
                            r_bg_rgb   <= rgb_t'(bg_rgb);
                            r_idx      <= '0;
                            r_state    <= LOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
